// File: rtl/multiples_read_sequencer.sv
// Multiples-memory read sequencer.
// Walks word_count consecutive addresses from base_address, captures each
// combinational read word into a 2-entry buffer and streams the buffer out.
//
// Handshake (data_out/data_valid/data_ready): a word transfers on every rising
// edge where data_valid && data_ready. data_valid never drops and data_out never
// changes while a word is offered but not accepted. data_valid does not depend
// on data_ready.
module multiples_read_sequencer #(
    parameter int NO_OF_ROW_BY_VECTOR_MODULES = 4,
    parameter int COUNT_WIDTH                 = 17
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic [31:0]                               base_address,
    input  logic [COUNT_WIDTH-1:0]                    word_count,
    output logic [31:0]                               multiples_read_address,
    input  logic [32*NO_OF_ROW_BY_VECTOR_MODULES-1:0] multiples_output,
    output logic [32*NO_OF_ROW_BY_VECTOR_MODULES-1:0] data_out,
    output logic                                      data_valid,
    input  logic                                      data_ready,
    output logic                                      busy,
    output logic                                      done,
    output logic [1:0]                                dbg_state
);

    localparam int DW = 32 * NO_OF_ROW_BY_VECTOR_MODULES;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic [DW-1:0]          buf_q [2];

    logic pop;
    logic push;

    // A pop frees a slot in the same cycle, so a full buffer can still accept
    // a new word while the head is being consumed (sustains 1 word/cycle).
    assign pop  = (cnt_q != 2'd0) && data_ready;
    assign push = (state_q == S_RUN) && (rem_q != '0) && ((cnt_q < 2'd2) || pop);

    // Next-state, address/remaining bookkeeping and buffer occupancy.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = base_address;
                    rem_d   = word_count;
                    state_d = (word_count != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (push) begin
                    addr_d = addr_q + 32'd1;
                    rem_d  = rem_q - COUNT_WIDTH'(1);
                    if (rem_q == COUNT_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_d == 2'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            rem_q    <= '0;
            cnt_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Word buffer: capture the memory word addressed this cycle on a push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else if (push) begin
            buf_q[wr_ptr_q] <= multiples_output;
        end
    end

    assign multiples_read_address = addr_q;
    assign data_out               = buf_q[rd_ptr_q];
    assign data_valid             = (cnt_q != 2'd0);
    assign busy                   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done                   = (state_q == S_DONE);
    assign dbg_state              = state_q;

endmodule

// File: tb/tb_multiples_read_sequencer.sv
// Directed bench for multiples_read_sequencer with a combinational memory model.
module tb_multiples_read_sequencer;

    localparam int N  = 4;
    localparam int DW = 32 * N;
    localparam int CW = 17;

    logic          clk;
    logic          reset;
    logic          start;
    logic [31:0]   base_address;
    logic [CW-1:0] word_count;
    logic [31:0]   multiples_read_address;
    logic [DW-1:0] multiples_output;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];

    int first_v;
    int last_v;
    int done_at;
    int done_pulses;
    bit busy_seen;

    multiples_read_sequencer #(
        .NO_OF_ROW_BY_VECTOR_MODULES(N),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .base_address           (base_address),
        .word_count             (word_count),
        .multiples_read_address (multiples_read_address),
        .multiples_output       (multiples_output),
        .data_out               (data_out),
        .data_valid             (data_valid),
        .data_ready             (data_ready),
        .busy                   (busy),
        .done                   (done),
        .dbg_state              (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: every lane is a distinct function of the address.
    function automatic logic [DW-1:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, a + 32'h0000_1111, ~a, a * 32'd3};
    endfunction

    assign multiples_output = mem_word(multiples_read_address);

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ready_of(input int mode, input int rel);
        if (mode == 1) return (rel % 3) == 0;
        return 1'b1;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_addr"},  multiples_read_address, '0);
        check_eq({tag, "_data"},  data_out, '0);
        check_eq({tag, "_valid"}, data_valid, '0);
        check_eq({tag, "_busy"},  busy, '0);
        check_eq({tag, "_done"},  done, '0);
        check_eq({tag, "_state"}, dbg_state, '0);
    endtask

    // One burst: start in cycle 0, then sample every cycle on the falling edge.
    // Optionally pulses start with a different base in cycle 3 (must be ignored).
    task automatic run_burst(input logic [31:0] base, input logic [CW-1:0] n,
                             input int mode, input bit poke, input int budget);
        int            rel;
        bit            stalled;
        logic [DW-1:0] held;
        logic [31:0]   a;
        exp_q.delete();
        for (int i = 0; i < int'(n); i++) begin
            a = base + 32'(i);
            exp_q.push_back(mem_word(a));
        end
        first_v = -1; last_v = -1; done_at = -1; done_pulses = 0; busy_seen = 0;
        stalled = 0; held = '0;
        @(posedge clk); #1;
        start = 1'b1; base_address = base; word_count = n; data_ready = 1'b1;
        rel = 1;
        @(posedge clk); #1;
        while (rel < budget) begin
            data_ready = ready_of(mode, rel);
            start = poke && (rel == 3);
            base_address = 32'h0000_5000;
            word_count = CW'(2);
            @(negedge clk);
            if (busy) busy_seen = 1;
            if (stalled) begin
                check_eq("stall_valid", data_valid, 1'b1);
                check_eq("stall_hold", data_out, held);
            end
            if (data_valid) begin
                if (first_v < 0) first_v = rel;
                last_v = rel;
            end
            if (done) begin
                done_pulses++;
                if (done_at < 0) done_at = rel;
            end
            if (data_valid && data_ready) begin
                if (exp_q.size() == 0) check_eq("extra_word", 1'b1, 1'b0);
                else check_eq("word", data_out, exp_q.pop_front());
            end
            stalled = data_valid && !data_ready;
            held = data_out;
            if (done_at >= 0 && rel >= done_at + 2) break;
            @(posedge clk); #1;
            rel++;
        end
        start = 1'b0;
        data_ready = 1'b1;
        check_eq("burst_finished", done_at >= 0, 1'b1);
        check_eq("words_left", exp_q.size(), 0);
        check_eq("done_pulses", done_pulses, 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_address = '0; word_count = '0; data_ready = 1'b0;
        #2;
        check_outputs_zero("reset");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // 1: base 10, 4 words, always ready
        run_burst(32'd10, CW'(4), 0, 1'b0, 40);
        check_eq("t1_first_valid", first_v, 2);
        check_eq("t1_last_valid", last_v, 5);
        check_eq("t1_done_at", done_at, 6);
        check_eq("t1_busy_seen", busy_seen, 1'b1);
        check_eq("t1_addr_after", multiples_read_address, 32'd14);

        // 2: base 0, 6 words, ready 1,0,0 pattern
        run_burst(32'd0, CW'(6), 1, 1'b0, 60);
        check_eq("t2_addr_after", multiples_read_address, 32'd6);

        // 3: zero-length burst
        run_burst(32'd77, CW'(0), 0, 1'b0, 20);
        check_eq("t3_done_at", done_at, 1);
        check_eq("t3_no_valid", first_v, -1);
        check_eq("t3_no_busy", busy_seen, 1'b0);

        // 4: address wrap
        run_burst(32'hFFFF_FFFE, CW'(3), 0, 1'b0, 40);
        check_eq("t4_done_at", done_at, 5);
        check_eq("t4_addr_after", multiples_read_address, 32'd1);

        // 6: start during RUN is ignored
        run_burst(32'd20, CW'(4), 0, 1'b1, 40);
        check_eq("t6_done_at", done_at, 6);
        check_eq("t6_addr_after", multiples_read_address, 32'd24);

        // 5: asynchronous reset on the second word of an 8-word burst
        @(posedge clk); #1;
        start = 1'b1; base_address = 32'd100; word_count = CW'(8); data_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("t5_second_valid", data_valid, 1'b1);
        check_eq("t5_second_word", data_out, mem_word(32'd101));
        #1 reset = 1'b1;
        #1 check_outputs_zero("t5_async");
        @(posedge clk); #1;
        check_outputs_zero("t5_held");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("t5_no_done", done, 1'b0);
        run_burst(32'd300, CW'(2), 0, 1'b0, 30);
        check_eq("t5_done_at", done_at, 4);
        check_eq("t5_addr_after", multiples_read_address, 32'd302);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
